// File: rtl/mixer_pkg.sv
// mixer_pkg
// Shared definitions for the multichannel mixer: FSM state encoding,
// accumulator sizing helper and the channel-count ceiling.
package mixer_pkg;

  localparam int MIXER_MAX_CHANNELS = 60;

  // Wide enough to index any legal channel count.
  localparam int IDX_W = $clog2(MIXER_MAX_CHANNELS);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MAC  = 2'd1;
  localparam state_t ST_SAT  = 2'd2;

  // Each term carries BITSIZE+2 significant bits (a full-scale negative
  // sample times a full-scale negative gain gives +2^BITSIZE after the
  // shift). Summing ch of them needs clog2(ch) more bits.
  function automatic int acc_width(input int bits, input int ch);
    return bits + $clog2(ch) + 2;
  endfunction

endpackage

// File: rtl/mixer_sat.sv
// mixer_sat
// Reduces the mixer accumulator to an output-width sample.
//   acc  in   ACC_W    signed accumulator
//   sat  out  BITSIZE  signed reduced sample
// Build option MIXER_SATURATE_EN: clamp to the signed BITSIZE range.
// Without it the low BITSIZE bits are passed through (two's-complement wrap).
module mixer_sat #(
  parameter int BITSIZE = 16,
  parameter int ACC_W   = 20
) (
  input  logic [ACC_W-1:0]   acc,
  output logic [BITSIZE-1:0] sat
);

`ifdef MIXER_SATURATE_EN
  logic fits;

  // The value fits when every bit from the output sign bit upward is a
  // copy of the accumulator sign.
  assign fits = (&acc[ACC_W-1:BITSIZE-1]) | ~(|acc[ACC_W-1:BITSIZE-1]);

  assign sat = fits          ? acc[BITSIZE-1:0] :
               acc[ACC_W-1]  ? {1'b1, {(BITSIZE-1){1'b0}}} :
                               {1'b0, {(BITSIZE-1){1'b1}}};
`else
  logic unused_hi;

  assign unused_hi = ^acc[ACC_W-1:BITSIZE];
  assign sat       = acc[BITSIZE-1:0];
`endif

endmodule

// File: rtl/multichannel_mixer.sv
// multichannel_mixer
// Frame-based gain-weighted mixer. A rising lrclk (seen against its
// registered copy) snapshots all samples and gains, then one channel per
// bclk is multiplied and accumulated, and the reduced sum is registered.
//   bclk      in   1                 sole clock
//   reset     in   1                 asynchronous active-high reset
//   lrclk     in   1                 frame strobe, sampled as data
//   in_bus    in   CHANNELS*BITSIZE  packed signed samples
//   gain_bus  in   CHANNELS*BITSIZE  packed signed Q1.(BITSIZE-2) gains
//   out       out  BITSIZE           signed mixed sample, held between updates
//   out_valid out  1                 one-cycle pulse when out updates
//   overrun   out  1                 one-cycle pulse when a frame is aborted
// Build option MIXER_SATURATE_EN: clamp the result instead of wrapping.
//
// state | meaning
// IDLE  | waiting for a frame start
// MAC   | accumulating channel idx (CHANNELS cycles)
// SAT   | reducing the accumulator into out
import mixer_pkg::*;

module multichannel_mixer #(
  parameter int BITSIZE  = 16,
  parameter int CHANNELS = 8
) (
  input  logic                         bclk,
  input  logic                         reset,
  input  logic                         lrclk,
  input  logic [CHANNELS*BITSIZE-1:0]  in_bus,
  input  logic [CHANNELS*BITSIZE-1:0]  gain_bus,
  output logic [BITSIZE-1:0]           out,
  output logic                         out_valid,
  output logic                         overrun
);

  localparam int ACC_W = acc_width(BITSIZE, CHANNELS);
  localparam int PW    = 2 * BITSIZE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  if (CHANNELS < 1 || CHANNELS > MIXER_MAX_CHANNELS) begin : g_bad_channels
    $error("multichannel_mixer: CHANNELS must be in 1..%0d", MIXER_MAX_CHANNELS);
  end

  state_t                        state;
  logic                          lrclk_q;
  logic [IDX_W-1:0]              idx;
  logic [ACC_W-1:0]              acc;
  logic [CHANNELS*BITSIZE-1:0]   in_q;
  logic [CHANNELS*BITSIZE-1:0]   gain_q;

  logic                          frame_start;
  logic [BITSIZE-1:0]            cur_s;
  logic [BITSIZE-1:0]            cur_g;
  logic [PW-1:0]                 prod;
  logic signed [PW-1:0]          shifted;
  logic [ACC_W+PW-1:0]           term_wide;
  logic [ACC_W-1:0]              term;
  logic                          unused_term;
  logic [BITSIZE-1:0]            sat_out;

  assign frame_start = lrclk & ~lrclk_q;

  assign cur_s = in_q[int'(idx)*BITSIZE +: BITSIZE];
  assign cur_g = gain_q[int'(idx)*BITSIZE +: BITSIZE];

  // Operands are sign-extended to full product width so the low PW bits
  // of the multiply are the exact signed product.
  assign prod    = {{BITSIZE{cur_s[BITSIZE-1]}}, cur_s} *
                   {{BITSIZE{cur_g[BITSIZE-1]}}, cur_g};
  assign shifted = $signed(prod) >>> (BITSIZE - 2);

  // Sign-extend, then keep the accumulator width; the discarded upper bits
  // are sign copies because the term never exceeds BITSIZE+2 bits.
  assign term_wide   = {{ACC_W{shifted[PW-1]}}, shifted};
  assign term        = term_wide[ACC_W-1:0];
  assign unused_term = ^term_wide[ACC_W+PW-1:ACC_W];

  mixer_sat #(
    .BITSIZE (BITSIZE),
    .ACC_W   (ACC_W)
  ) u_sat (
    .acc (acc),
    .sat (sat_out)
  );

  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      lrclk_q   <= 1'b0;
      idx       <= '0;
      acc       <= '0;
      in_q      <= '0;
      gain_q    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      lrclk_q   <= lrclk;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      if (frame_start) begin
        // A start while busy abandons the running frame without touching out.
        in_q    <= in_bus;
        gain_q  <= gain_bus;
        acc     <= '0;
        idx     <= '0;
        state   <= ST_MAC;
        overrun <= (state != ST_IDLE);
      end else begin
        case (state)
          ST_MAC: begin
            acc <= acc + term;
            if (idx == LAST_IDX) begin
              state <= ST_SAT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          ST_SAT: begin
            out       <= sat_out;
            out_valid <= 1'b1;
            state     <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multichannel_mixer.sv
// tb_multichannel_mixer
// Scoreboard bench for multichannel_mixer at BITSIZE=16, CHANNELS=4.
// Build option MIXER_SATURATE_EN selects the clamping expectations.
module tb_multichannel_mixer;

  localparam int B  = 16;
  localparam int CH = 4;

  logic              bclk;
  logic              reset;
  logic              lrclk;
  logic [CH*B-1:0]   in_bus;
  logic [CH*B-1:0]   gain_bus;
  logic [B-1:0]      out;
  logic              out_valid;
  logic              overrun;

  multichannel_mixer #(.BITSIZE(B), .CHANNELS(CH)) dut (
    .bclk      (bclk),
    .reset     (reset),
    .lrclk     (lrclk),
    .in_bus    (in_bus),
    .gain_bus  (gain_bus),
    .out       (out),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  typedef struct {
    longint val;
    longint cyc;
  } exp_t;

  exp_t   sb[$];
  longint ovq[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint exp_hold = 0;
  int     in_v[CH];
  int     g_v[CH];

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  always @(posedge bclk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic apply();
    for (int k = 0; k < CH; k++) begin
      in_bus[k*B +: B]   = B'(in_v[k]);
      gain_bus[k*B +: B] = B'(g_v[k]);
    end
  endtask

  function automatic longint model();
    longint acc = 0;
    for (int k = 0; k < CH; k++)
      acc += (longint'(in_v[k]) * longint'(g_v[k])) >>> 14;
`ifdef MIXER_SATURATE_EN
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
`else
    return longint'($signed(16'(acc)));
`endif
  endfunction

  // Monitor: every cycle checks out against the scoreboard or the held value.
  initial begin
    exp_t e;
    forever begin
      @(posedge bclk);
      #1;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_value", longint'($signed(out)), e.val);
          check("valid_cycle", cyc, e.cyc);
          exp_hold = e.val;
        end
      end else begin
        check("out_hold", longint'($signed(out)), exp_hold);
      end
      if (overrun) begin
        if (ovq.size() == 0) check("unexpected_overrun", 1, 0);
        else check("overrun_cycle", cyc, ovq.pop_front());
      end
    end
  end

  // One frame start; expected result pushed with its out_valid cycle (E+CH+1).
  task automatic run_frame(input longint exp, input bit push);
    longint e;
    @(negedge bclk);
    lrclk = 1'b1;
    e = cyc + 1;
    if (push) sb.push_back('{exp, e + CH + 1});
    @(negedge bclk);
    lrclk = 1'b0;
    repeat (7) @(negedge bclk);
  endtask

  initial begin
    longint e;
    longint ex;
    reset = 1'b1;
    lrclk = 1'b0;
    for (int k = 0; k < CH; k++) begin
      in_v[k] = 0;
      g_v[k]  = 0;
    end
    apply();
    #12;
    check("reset_out", longint'($signed(out)), 0);
    check("reset_valid", longint'(out_valid), 0);
    check("reset_overrun", longint'(overrun), 0);
    @(negedge bclk);
    reset = 1'b0;
    repeat (2) @(negedge bclk);

    // Unity gain on channel 0.
    in_v[0] = 1000; g_v[0] = 16'h4000; apply();
    run_frame(1000, 1);

    // Half gain, floor rounding on both signs.
    in_v[0] = 1001; g_v[0] = 16'h2000; apply();
    run_frame(500, 1);
    in_v[0] = -1001; apply();
    run_frame(-501, 1);

    // Full-scale sums.
    for (int k = 0; k < CH; k++) begin
      in_v[k] = 30000; g_v[k] = 16'h4000;
    end
    apply();
`ifdef MIXER_SATURATE_EN
    run_frame(32767, 1);
`else
    run_frame(-11072, 1);
`endif
    for (int k = 0; k < CH; k++) in_v[k] = -20000;
    apply();
`ifdef MIXER_SATURATE_EN
    run_frame(-32768, 1);
`else
    run_frame(-14464, 1);
`endif

    // Overrun: second rise at E+2 aborts and restarts with new snapshot.
    for (int k = 0; k < CH; k++) in_v[k] = 0;
    in_v[0] = 1000; g_v[0] = 16'h4000; apply();
    @(negedge bclk); lrclk = 1'b1; e = cyc + 1;
    @(negedge bclk); lrclk = 1'b0;
    in_v[0] = 2000; apply();
    @(negedge bclk); lrclk = 1'b1;
    check("overrun_edge", cyc + 1, e + 2);
    ovq.push_back(e + 2);
    sb.push_back('{2000, e + 2 + CH + 1});
    @(negedge bclk); lrclk = 1'b0;
    repeat (9) @(negedge bclk);

    // Reset between E+1 and E+2 discards the frame.
    in_v[0] = 3000; apply();
    @(negedge bclk); lrclk = 1'b1;
    @(negedge bclk); lrclk = 1'b0;
    @(negedge bclk);
    reset = 1'b1;
    exp_hold = 0;
    #1;
    check("midframe_reset_out", longint'($signed(out)), 0);
    @(negedge bclk); reset = 1'b0;
    repeat (8) @(negedge bclk);
    run_frame(3000, 1);

    // Inputs changed right after E must not leak into the frame.
    for (int k = 0; k < CH; k++) begin
      in_v[k] = 100 * (k + 1); g_v[k] = 16'h4000;
    end
    apply();
    ex = model();
    check("model_snapshot", ex, 1000);
    @(negedge bclk); lrclk = 1'b1; e = cyc + 1;
    sb.push_back('{ex, e + CH + 1});
    @(negedge bclk); lrclk = 1'b0;
    for (int k = 0; k < CH; k++) begin
      in_v[k] = -7777; g_v[k] = 16'h1234;
    end
    apply();
    repeat (8) @(negedge bclk);

    // Random frames against the arithmetic model.
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < CH; k++) begin
        in_v[k] = int'($urandom_range(0, 65535)) - 32768;
        g_v[k]  = int'($urandom_range(0, 65535)) - 32768;
      end
      apply();
      run_frame(model(), 1);
    end

    repeat (12) @(negedge bclk);
    check("sb_drained", longint'(sb.size()), 0);
    check("ovq_drained", longint'(ovq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
